unidade_controle_mc: RTL and testbench
======================================

// Module: unidade_controle_mc
// PURPOSE
//  Multi-cycle control FSM that sequences the processor datapath (ROM fetch, register bank, ULA, RAM).
//  Owns the PC and drives every datapath strobe: instruction-register load, reg_write, ram we/re, AluOP, ULA enable and mux selects.
//  Sits between the ROM address port and the decode fields taken from the ROM word.
// PARAMETERS
//  ADDR_WIDTH  8   PC / ROM address width
//  START_PC    0   PC value loaded on reset
// PORTS
//  clock        in   1   sole clock, rising edge
//  reset        in   1   synchronous, active-high
//  run          in   1   leave IDLE and begin fetching at the current PC
//  opcode       in   6   instruction word bits [31:26]
//  imediato     in   14  bits [13:0], two's complement branch offset
//  salto        in   26  bits [25:0], jump target; low ADDR_WIDTH bits used
//  zero         in   1   ULA ZERO flag
//  pc           out  ADDR_WIDTH  ROM address
//  ir_load      out  1   capture the ROM word into the instruction register
//  reg_write    out  1   register bank write strobe
//  mem_write    out  1   RAM we
//  mem_read     out  1   RAM re
//  alu_op       out  4   AluOP to ULA_controle
//  alu_enable   out  1   ULA enable
//  alu_src_imm  out  1   ULA B operand = sign-extended imediato
//  mem_to_reg   out  1   write-back data taken from RAM, else from ULA
//  reg_dst_rt   out  1   write register = rt, else rd
//  halted       out  1   in HALT state
//  state_dbg    out  3   current state encoding
// BEHAVIOUR
//  - Reset: state=IDLE, pc=START_PC, halted=0; all strobes 0; alu_op=0.
//  - States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
//  - Transitions: IDLE -run-> FETCH. FETCH -> DECODE (ir_load=1).
//    DECODE -> HALT for HLT, else -> EXEC. EXEC -> MEM for LW/SW, WB for R/ADDI, FETCH for BEQ/J/unknown.
//    MEM -> WB for LW, FETCH for SW. WB -> FETCH.
//  - Opcodes: R=000000, ADDI=000001, J=000010, BEQ=000100, LW=000110, SW=000111, HLT=111111.
//    Any other opcode executes as a NOP: EXEC then FETCH, no strobes.
//  - AluOP: 0000 add (LW/SW/ADDI), 0001 sub (BEQ), 0010 R-type (funct decides).
//    alu_enable=1 in EXEC, and in MEM/WB for LW/SW/R/ADDI.
//  - Strobes are Moore outputs of the registered state plus the latched opcode; the opcode is latched at the end of DECODE.
//    mem_write=1 only in MEM for SW. mem_read=1 in MEM and WB for LW.
//    reg_write=1 only in WB. mem_to_reg=1 only for LW. reg_dst_rt=1 for LW/ADDI. alu_src_imm=1 for LW/SW/ADDI.
//  - PC update, always at the last cycle of the instruction:
//    J: pc = salto[ADDR_WIDTH-1:0].
//    BEQ with zero=1 in EXEC: pc = pc+1+sext(imediato), truncated to ADDR_WIDTH.
//    Otherwise: pc = pc+1.
//  - Latency in cycles (FETCH to next FETCH): BEQ/J/NOP 3, SW/R/ADDI 4, LW 5. HLT: 2 cycles, then stays in HALT.
//  - The PC wraps modulo 2^ADDR_WIDTH; there is no overflow flag.
//  - HALT: PC is frozen and no strobes are asserted. Only reset leaves HALT; run is ignored in HALT.
//  - reset asserted mid-instruction: the next state is IDLE and any pending write is dropped.
//    A reset in the same cycle as WB suppresses reg_write in the following cycle.
//  - run is sampled only in IDLE; a run level held high afterwards has no effect.
// CONFIGURATION
//  UC_STEP_EN defined: adds input `step`. After WB/the last state of each instruction the FSM returns to IDLE, not FETCH.
//    The next instruction starts on run or step. halted is unaffected.
//  UC_STEP_EN undefined: no step port; instructions execute back-to-back as above.
// STRUCTURE
//  - uc_pkg: opcode localparams, state encodings, AluOP codes.
//  - Sub-module uc_pc_next (combinational): next-PC select (+1 / branch / jump) with sign extension.
//  - Top level: state register, latched opcode, output decode.
// TESTING
//  1. reset=1 for 2 cycles, then run=1 -> state IDLE->FETCH, pc=0, all strobes 0 during reset.
//  2. R-type (opcode 0) at pc=0 -> reg_write=1 only in cycle 4 (WB), alu_op=0010, pc=1 at the next FETCH.
//  3. LW at pc=3 -> mem_read=1 in MEM and WB, mem_to_reg=1, reg_dst_rt=1, 5 cycles, pc=4.
//  4. BEQ, imediato=14'h3FFE (-2), zero=1 at pc=10 -> pc=9. Same with zero=0 -> pc=11.
//  5. J with salto=26'h00000FF, ADDR_WIDTH=8 -> pc=8'hFF. Then an instruction at pc=FF -> pc wraps to 0.
//  6. HLT -> halted=1 and pc frozen for 20 cycles despite run=1; reset asserted in LW MEM -> IDLE next cycle, no reg_write.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes, AluOP codes.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package uc_pkg;

  // FSM state encodings; also exported on state_dbg
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  // Instruction word bits [31:26]
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b000110;
  localparam logic [5:0] OP_SW   = 6'b000111;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  // AluOP codes consumed by ULA_controle
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;

  // Instructions that keep the ULA busy past EXEC (address calc or result hold)
  function automatic logic uses_alu_late(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/uc_pc_next.sv
// Next-PC select: pc+1, pc+1+sext(imediato) for a taken branch, or salto for a jump.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller decides when to load the result into the PC.
// Ports: pc (current), jump, branch_taken, imediato (14b signed offset),
//        salto (26b target, low ADDR_WIDTH bits used), pc_nxt (result, wraps mod 2^ADDR_WIDTH).
module uc_pc_next #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  jump,
  input  logic                  branch_taken,
  input  logic [13:0]           imediato,
  input  logic [25:0]           salto,
  output logic [ADDR_WIDTH-1:0] pc_nxt
);

  logic [31:0] offset;
  logic [31:0] seq_target;
  logic        unused_bits;

  // Sum done at 32 bits and truncated, which gives the modulo-2^ADDR_WIDTH wrap.
  assign offset     = {{18{imediato[13]}}, imediato};
  assign seq_target = 32'(pc) + 32'd1 + (branch_taken ? offset : 32'd0);

  always_comb begin
    pc_nxt = seq_target[ADDR_WIDTH-1:0];
    if (jump) begin
      pc_nxt = salto[ADDR_WIDTH-1:0];
    end
  end

  // High bits are intentionally discarded by the wrap / narrow ROM address.
  assign unused_bits = ^{seq_target[31:ADDR_WIDTH], salto[25:ADDR_WIDTH]};

endmodule

// File: rtl/unidade_controle_mc.sv
// Multi-cycle control FSM: owns the PC and drives all datapath strobes from registered state + latched opcode.
// Latency: FETCH-to-FETCH 3 (BEQ/J/NOP), 4 (SW/R/ADDI), 5 (LW); HLT parks in HALT after 2 cycles.
// Backpressure: none; run starts fetching from IDLE, only reset leaves HALT.
// Ports: clock, reset (sync, active-high), run, opcode/imediato/salto (ROM word fields), zero (ULA flag),
//        pc, ir_load, reg_write, mem_write, mem_read, alu_op, alu_enable, alu_src_imm, mem_to_reg,
//        reg_dst_rt, halted, state_dbg.
// Build option: define UC_STEP_EN to add a step input; each instruction then returns to IDLE
//               and the next one starts on run or step.
module unidade_controle_mc
  import uc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] START_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
`ifdef UC_STEP_EN
  input  logic                  step,
`endif
  input  logic [5:0]            opcode,
  input  logic [13:0]           imediato,
  input  logic [25:0]           salto,
  input  logic                  zero,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  ir_load,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [3:0]            alu_op,
  output logic                  alu_enable,
  output logic                  alu_src_imm,
  output logic                  mem_to_reg,
  output logic                  reg_dst_rt,
  output logic                  halted,
  output logic [2:0]            state_dbg
);

`ifdef UC_STEP_EN
  localparam logic [2:0] ST_DONE = ST_IDLE;
`else
  localparam logic [2:0] ST_DONE = ST_FETCH;
`endif

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [5:0]            opc_q;
  logic                  start;
  logic                  instr_done;
  logic                  in_exec_phase;
  logic                  do_jump;
  logic                  do_branch;
  logic [ADDR_WIDTH-1:0] pc_nxt;

`ifdef UC_STEP_EN
  assign start = run | step;
`else
  assign start = run;
`endif

  // ---------------- next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      // opc_q is not valid yet in DECODE, so the HLT test uses the live ROM field
      ST_DECODE: state_nxt = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        case (opc_q)
          OP_LW, OP_SW:  state_nxt = ST_MEM;
          OP_R, OP_ADDI: state_nxt = ST_WB;
          default:       state_nxt = ST_DONE;
        endcase
      end
      ST_MEM:    state_nxt = (opc_q == OP_LW) ? ST_WB : ST_DONE;
      ST_WB:     state_nxt = ST_DONE;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign in_exec_phase = (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB);
  // Last cycle of an instruction: leaving an execute-phase state for the done state
  assign instr_done    = in_exec_phase && (state_nxt == ST_DONE);

  // Branch/jump resolve in EXEC, which is also their last cycle
  assign do_jump   = (state == ST_EXEC) && (opc_q == OP_J);
  assign do_branch = (state == ST_EXEC) && (opc_q == OP_BEQ) && zero;

  uc_pc_next #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pc_next (
    .pc           (pc),
    .jump         (do_jump),
    .branch_taken (do_branch),
    .imediato     (imediato),
    .salto        (salto),
    .pc_nxt       (pc_nxt)
  );

  // ---------------- state, opcode latch, PC ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      pc    <= START_PC;
      opc_q <= OP_R;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) begin
        opc_q <= opcode;
      end
      if (instr_done) begin
        pc <= pc_nxt;
      end
    end
  end

  // ---------------- Moore output decode ----------------
  always_comb begin
    ir_load     = (state == ST_FETCH);
    reg_write   = (state == ST_WB);
    mem_write   = (state == ST_MEM) && (opc_q == OP_SW);
    mem_read    = ((state == ST_MEM) || (state == ST_WB)) && (opc_q == OP_LW);
    mem_to_reg  = in_exec_phase && (opc_q == OP_LW);
    reg_dst_rt  = in_exec_phase && ((opc_q == OP_LW) || (opc_q == OP_ADDI));
    alu_src_imm = in_exec_phase && ((opc_q == OP_LW) || (opc_q == OP_SW) || (opc_q == OP_ADDI));
    // Unknown opcodes (and J) pass through EXEC as NOPs with the ULA idle
    alu_enable  = ((state == ST_EXEC) && (uses_alu_late(opc_q) || (opc_q == OP_BEQ))) ||
                  (((state == ST_MEM) || (state == ST_WB)) && uses_alu_late(opc_q));
    alu_op      = ALU_ADD;
    if (alu_enable) begin
      case (opc_q)
        OP_BEQ:  alu_op = ALU_SUB;
        OP_R:    alu_op = ALU_RTYPE;
        default: alu_op = ALU_ADD;
      endcase
    end
    halted      = (state == ST_HALT);
    state_dbg   = state;
  end

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Directed bench for unidade_controle_mc (default build, ADDR_WIDTH=8, START_PC=0).
// Each instruction is run from FETCH to the next FETCH while per-cycle strobe masks are collected.
// Expected masks, latencies and PCs are hand-derived from the instruction set definition.
module tb_unidade_controle_mc;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [13:0] imediato = 14'd0;
  logic [25:0] salto = 26'd0;
  logic        zero = 1'b0;
  logic [7:0]  pc;
  logic        ir_load, reg_write, mem_write, mem_read;
  logic [3:0]  alu_op;
  logic        alu_enable, alu_src_imm, mem_to_reg, reg_dst_rt, halted;
  logic [2:0]  state_dbg;

  int tests = 0;
  int fails = 0;

  // per-cycle masks: bit i = signal value in cycle i, cycle 0 = FETCH
  logic [9:0] m_irl, m_rw, m_mw, m_mr, m_m2r, m_rdt, m_imm, m_ae;
  logic [3:0] exec_alu_op;
  int         len;

  unidade_controle_mc #(.ADDR_WIDTH(8), .START_PC(8'd0)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .imediato(imediato),
    .salto(salto), .zero(zero), .pc(pc), .ir_load(ir_load), .reg_write(reg_write),
    .mem_write(mem_write), .mem_read(mem_read), .alu_op(alu_op), .alu_enable(alu_enable),
    .alu_src_imm(alu_src_imm), .mem_to_reg(mem_to_reg), .reg_dst_rt(reg_dst_rt),
    .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs one instruction starting from a sampled FETCH; stops at FETCH/HALT/IDLE or after 10 cycles.
  task automatic run_instr(input logic [5:0] op, input logic [13:0] imm, input logic [25:0] sal,
                           input logic z);
    logic done;
    opcode = op; imediato = imm; salto = sal; zero = z;
    m_irl = '0; m_rw = '0; m_mw = '0; m_mr = '0; m_m2r = '0; m_rdt = '0; m_imm = '0; m_ae = '0;
    exec_alu_op = 4'hx;
    len = 0;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      m_irl[i] = ir_load; m_rw[i] = reg_write; m_mw[i] = mem_write; m_mr[i] = mem_read;
      m_m2r[i] = mem_to_reg; m_rdt[i] = reg_dst_rt; m_imm[i] = alu_src_imm; m_ae[i] = alu_enable;
      if (state_dbg == S_EXEC) exec_alu_op = alu_op;
      tick();
      len = i + 1;
      if (state_dbg == S_FETCH || state_dbg == S_HALT || state_dbg == S_IDLE) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL instr_timeout op=%b state=%0d after %0d cycles, required return to FETCH", op, state_dbg, len);
    end
  endtask

  task automatic chk_len_pc(input string name, input int exp_len, input logic [7:0] exp_pc);
    tests++;
    if (len !== exp_len) begin
      fails++; $display("FAIL %s_latency got %0d required %0d", name, len, exp_len);
    end
    tests++;
    if (pc !== exp_pc) begin
      fails++; $display("FAIL %s_pc got %h required %h", name, pc, exp_pc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1;
    tick(); tick();
    tests++;
    if ({state_dbg, pc, halted} !== {S_IDLE, 8'd0, 1'b0}) begin
      fails++; $display("FAIL reset_state state=%0d pc=%h halted=%b required 0/00/0", state_dbg, pc, halted);
    end
    tests++;
    if ({ir_load, reg_write, mem_write, mem_read, alu_enable, alu_src_imm, mem_to_reg, reg_dst_rt, alu_op} !== 12'd0) begin
      fails++; $display("FAIL reset_strobes got nonzero strobes alu_op=%b rw=%b, required all 0", alu_op, reg_write);
    end
    reset = 1'b0;
    tick();
    run = 1'b0;
    tests++;
    if ({state_dbg, pc, ir_load} !== {S_FETCH, 8'd0, 1'b1}) begin
      fails++; $display("FAIL run_to_fetch state=%0d pc=%h ir_load=%b required 1/00/1", state_dbg, pc, ir_load);
    end
  endtask

  task automatic test_rtype();
    run_instr(6'b000000, 14'd0, 26'd0, 1'b0);
    chk_len_pc("rtype", 4, 8'd1);
    tests++;
    if (m_rw !== 10'b0000001000) begin
      fails++; $display("FAIL rtype_reg_write mask %b required %b", m_rw, 10'b0000001000);
    end
    tests++;
    if (m_irl !== 10'b0000000001) begin
      fails++; $display("FAIL rtype_ir_load mask %b required %b", m_irl, 10'b0000000001);
    end
    tests++;
    if (exec_alu_op !== 4'b0010) begin
      fails++; $display("FAIL rtype_alu_op got %b required 0010", exec_alu_op);
    end
  endtask

  task automatic test_addi_sw();
    run_instr(6'b000001, 14'd5, 26'd0, 1'b0);
    chk_len_pc("addi", 4, 8'd2);
    tests++;
    if ({m_rw[3], m_rdt[3], m_imm[2], exec_alu_op} !== {3'b111, 4'b0000}) begin
      fails++; $display("FAIL addi_strobes rw=%b rdt=%b imm=%b aluop=%b required 1 1 1 0000",
                        m_rw[3], m_rdt[3], m_imm[2], exec_alu_op);
    end
    run_instr(6'b000111, 14'd4, 26'd0, 1'b0);
    chk_len_pc("sw", 4, 8'd3);
    tests++;
    if ({m_mw, m_rw, m_mr} !== {10'b0000001000, 10'd0, 10'd0}) begin
      fails++; $display("FAIL sw_strobes mw=%b rw=%b mr=%b required mw=0000001000 rw=0 mr=0", m_mw, m_rw, m_mr);
    end
  endtask

  task automatic test_lw();
    run_instr(6'b000110, 14'd8, 26'd0, 1'b0);
    chk_len_pc("lw", 5, 8'd4);
    tests++;
    if (m_mr !== 10'b0000011000) begin
      fails++; $display("FAIL lw_mem_read mask %b required %b", m_mr, 10'b0000011000);
    end
    tests++;
    if ({m_rw, m_mw, m_m2r[4], m_rdt[4], m_ae[4]} !== {10'b0000010000, 10'd0, 3'b111}) begin
      fails++; $display("FAIL lw_wb rw=%b mw=%b m2r=%b rdt=%b ae=%b required rw=0000010000 mw=0 1 1 1",
                        m_rw, m_mw, m_m2r[4], m_rdt[4], m_ae[4]);
    end
  endtask

  task automatic test_branch();
    run_instr(6'b000010, 14'd0, 26'd10, 1'b0);
    chk_len_pc("j_to_10", 3, 8'd10);
    run_instr(6'b000100, 14'h3FFE, 26'd0, 1'b1);
    chk_len_pc("beq_taken", 3, 8'd9);
    tests++;
    if (exec_alu_op !== 4'b0001) begin
      fails++; $display("FAIL beq_alu_op got %b required 0001", exec_alu_op);
    end
    run_instr(6'b000010, 14'd0, 26'd10, 1'b0);
    run_instr(6'b000100, 14'h3FFE, 26'd0, 1'b0);
    chk_len_pc("beq_not_taken", 3, 8'd11);
  endtask

  task automatic test_jump_wrap();
    run_instr(6'b000010, 14'd0, 26'h00000FF, 1'b0);
    chk_len_pc("j_ff", 3, 8'hFF);
    run_instr(6'b100000, 14'd0, 26'd0, 1'b0);  // unknown opcode: NOP
    chk_len_pc("nop_wrap", 3, 8'h00);
    tests++;
    if ({m_rw, m_mw, m_mr} !== 30'd0) begin
      fails++; $display("FAIL nop_strobes rw=%b mw=%b mr=%b required all 0", m_rw, m_mw, m_mr);
    end
  endtask

  task automatic test_halt();
    int bad;
    run_instr(6'b111111, 14'd0, 26'h0000033, 1'b1);
    tests++;
    if ({len, state_dbg, halted} !== {32'd2, S_HALT, 1'b1}) begin
      fails++; $display("FAIL hlt_entry len=%0d state=%0d halted=%b required 2/6/1", len, state_dbg, halted);
    end
    run = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (state_dbg !== S_HALT || halted !== 1'b1 || pc !== 8'h00 ||
          {ir_load, reg_write, mem_write, mem_read, alu_enable} !== 5'd0) bad++;
    end
    run = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL halt_hold %0d bad cycles (last state=%0d pc=%h), required 0", bad, state_dbg, pc);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1; tick(); tick();
    reset = 1'b0; run = 1'b1; tick(); run = 1'b0;
    opcode = 6'b000110;
    tick(); tick(); tick();
    tests++;
    if ({state_dbg, mem_read} !== {S_MEM, 1'b1}) begin
      fails++; $display("FAIL lw_reach_mem state=%0d mr=%b required 4/1", state_dbg, mem_read);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    tests++;
    if ({state_dbg, reg_write, mem_read, pc} !== {S_IDLE, 1'b0, 1'b0, 8'd0}) begin
      fails++; $display("FAIL reset_in_mem state=%0d rw=%b mr=%b pc=%h required 0/0/0/00",
                        state_dbg, reg_write, mem_read, pc);
    end
    run = 1'b1; tick(); run = 1'b0;
    opcode = 6'b000000;
    tick(); tick(); tick();
    tests++;
    if ({state_dbg, reg_write} !== {S_WB, 1'b1}) begin
      fails++; $display("FAIL r_reach_wb state=%0d rw=%b required 5/1", state_dbg, reg_write);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    tests++;
    if ({state_dbg, reg_write, pc} !== {S_IDLE, 1'b0, 8'd0}) begin
      fails++; $display("FAIL reset_in_wb state=%0d rw=%b pc=%h required 0/0/00", state_dbg, reg_write, pc);
    end
    // run not asserted: must stay in IDLE
    tick(); tick();
    tests++;
    if (state_dbg !== S_IDLE) begin
      fails++; $display("FAIL idle_hold state=%0d required 0", state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_addi_sw();
    test_lw();
    test_branch();
    test_jump_wrap();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
